change_dispenser: RTL

Pays out vending change as discrete physical coins. Accepts a change amount in cents from the vending controller, breaks it greedily into 50/25/10/5-cent coins, and issues one request per coin to the coin-hopper mechanism over a req/ack handshake with inter-coin spacing. Sits between the vending FSM's change result and the hopper driver pins. Reports completion, shortfall, and coins paid.

---
 rtl/change_dispenser_if.sv | 30 +++
 rtl/change_dispenser.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// Signal bundle between the vending controller / coin hopper and change_dispenser.
// master = controller + hopper side, slave = dispenser side.
interface change_dispenser_if;
   logic        start;
   logic [11:0] amount;
   logic        abort;
   logic        refill;
   logic        coin_ack;
   logic        coin_req;
   logic [1:0]  coin_sel;
   logic        busy;
   logic        done;
   logic        fault;
   logic [11:0] remaining;
   logic [7:0]  coin_count;
   logic [3:0]  low_stock;
   logic [2:0]  state_dbg;

   // coin_req rises with a stable coin_sel and stays high until the cycle after
   // coin_ack is seen or the ack timeout expires; coin_ack only counts while coin_req=1.
   modport master (
      output start, amount, abort, refill, coin_ack,
      input  coin_req, coin_sel, busy, done, fault, remaining, coin_count, low_stock, state_dbg
   );

   modport slave (
      input  start, amount, abort, refill, coin_ack,
      output coin_req, coin_sel, busy, done, fault, remaining, coin_count, low_stock, state_dbg
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy 50/25/10/5 coin payout over a req/ack hopper handshake with inter-coin gap.
// Define CHANGE_STOCK_EN to add per-denomination stock counters (refill / low_stock).
module change_dispenser #(
   parameter int GAP_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 1000,
   parameter int STOCK_INIT  = 20
) (
   input logic                 clk,
   input logic                 rst,
   change_dispenser_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, PICK, REQ, GAP, DONE, FAULT} state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt;
   logic [1:0]  sel_q;
   logic        req_q, busy_q, done_q, fault_q;
   logic [11:0] remaining_q;
   logic [7:0]  count_q;
   logic [3:0]  avail;
   logic        pick_found;
   logic [1:0]  pick_sel;
   logic        pay;

   function automatic logic [11:0] denom_of(input logic [1:0] s);
      case (s)
         2'd0:    denom_of = 12'd50;
         2'd1:    denom_of = 12'd25;
         2'd2:    denom_of = 12'd10;
         default: denom_of = 12'd5;
      endcase
   endfunction

   // Descending scan so the last hit (and the one kept) is the largest coin.
   always_comb begin
      pick_found = 1'b0;
      pick_sel   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (avail[i] && remaining_q >= denom_of(2'(i))) begin
            pick_found = 1'b1;
            pick_sel   = 2'(i);
         end
      end
   end

   assign pay = (state == REQ) && bus.coin_ack && !bus.abort;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = PICK;
         PICK:    if (pick_found) state_nxt = REQ;
                  else if (remaining_q == 12'd0) state_nxt = DONE;
                  else state_nxt = FAULT;
         REQ:     if (bus.coin_ack) state_nxt = GAP;
                  else if (cnt == 16'(ACK_TIMEOUT - 1)) state_nxt = FAULT;
         GAP:     if (cnt == 16'(GAP_CYCLES - 1)) state_nxt = PICK;
         DONE:    state_nxt = IDLE;
         FAULT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         sel_q       <= 2'd0;
         req_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         remaining_q <= '0;
         count_q     <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
         // Outputs decoded from the next state so they line up with the state register.
         req_q   <= (state_nxt == REQ);
         busy_q  <= (state_nxt != IDLE);
         done_q  <= (state_nxt == DONE) || (state_nxt == FAULT);
         fault_q <= (state_nxt == FAULT);
         if (state == IDLE && bus.start && !bus.abort) begin
            remaining_q <= bus.amount;
            count_q     <= '0;
         end
         if (state == PICK && pick_found) sel_q <= pick_sel;
         if (pay) begin
            remaining_q <= remaining_q - denom_of(sel_q);
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
         end
      end
   end

`ifdef CHANGE_STOCK_EN
   logic [7:0] stock [4];
   logic [7:0] stock_nxt [4];
   logic [3:0] low_q;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stock_nxt[i] = stock[i];
         if (state == IDLE && bus.refill) stock_nxt[i] = 8'(STOCK_INIT);
      end
      if (pay) stock_nxt[sel_q] = stock[sel_q] - 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) stock[i] <= 8'(STOCK_INIT);
         low_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            stock[i] <= stock_nxt[i];
            low_q[i] <= (stock_nxt[i] == 8'd0);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) avail[i] = (stock[i] != 8'd0);
   end

   assign bus.low_stock = low_q;
`else
   logic       unused_refill;
   logic [7:0] unused_stock_init;

   assign unused_refill     = bus.refill;
   assign unused_stock_init = 8'(STOCK_INIT);
   assign avail             = 4'b1111;
   assign bus.low_stock     = 4'b0000;
`endif

   assign bus.coin_req   = req_q;
   assign bus.coin_sel   = sel_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.fault      = fault_q;
   assign bus.remaining  = remaining_q;
   assign bus.coin_count = count_q;
   assign bus.state_dbg  = state;

endmodule
